// File: rtl/xor_unit_scheduler_pkg.sv
// Shared constants for the XOR unit scheduler.
//   ST_*  : FSM state encoding (IDLE -> SETTLE -> DONE -> IDLE)
//   CNT_W : settle counter width, covers SETTLE_CYCLES up to 15
package xor_sched_pkg;
  localparam int         CNT_W     = 4;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
endpackage

// File: rtl/xor_unit_scheduler_rr_pick.sv
// Combinational round-robin winner select.
//   req     : request vector
//   ptr     : index where the search starts (wraps past N_REQ-1 to 0)
//   gnt_oh  : one-hot winner, zero when no request
//   win_idx : binary winner index, zero when no request
//   any_req : at least one request present
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [PW-1:0]    win_idx,
  output logic             any_req
);
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt_oh[idx] = 1'b1;
        win_idx     = idx;
      end
    end
    any_req = found;
  end
endmodule

// File: rtl/xor_unit_scheduler.sv
// Round-robin scheduler sharing one external, delay-annotated XOR unit
// between N_REQ requesters. The winner's operands are latched and driven
// to the unit, the gate path is given SETTLE_CYCLES to resolve, then the
// unit output is captured, returned and checked against a_lat^b_lat.
//   clk, rst_n   : clock, async active-low reset
//   req          : per-requester request level
//   a_in, b_in   : per-requester operands (slice i = requester i)
//   gnt          : one-hot grant, latch through DONE
//   done         : one-hot single-cycle completion pulse
//   result       : captured unit output, held until next DONE
//   mismatch     : captured output != a_lat^b_lat, held until next DONE
//   xu_a, xu_b   : operands to the shared unit
//   xu_z         : shared unit output
//   busy         : high in SETTLE and DONE
module xor_unit_scheduler
  import xor_sched_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int W             = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0][W-1:0] a_in,
  input  logic [N_REQ-1:0][W-1:0] b_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [W-1:0]            result,
  output logic                    mismatch,
  output logic [W-1:0]            xu_a,
  output logic [W-1:0]            xu_b,
  input  logic [W-1:0]            xu_z,
  output logic                    busy
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     a_lat_q, a_lat_d;
  logic [W-1:0]     b_lat_q, b_lat_d;
  logic [W-1:0]     res_q, res_d;
  logic             mis_q, mis_d;

  logic [N_REQ-1:0] pick_oh;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

  // Arbitration runs on the sampled request vector, so a request seen at
  // one edge is granted at the next.
  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req     (req_q),
    .ptr     (ptr_q),
    .gnt_oh  (pick_oh),
    .win_idx (pick_idx),
    .any_req (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    req_d   = '0;
    cnt_d   = cnt_q;
    a_lat_d = a_lat_q;
    b_lat_d = b_lat_q;
    res_d   = res_q;
    mis_d   = mis_q;
    case (state_q)
      ST_IDLE: begin
        // Sample stage is emptied whenever it is consumed or the block is
        // busy, so IDLE always spends a cycle re-sampling after DONE.
        req_d = (req_q == '0) ? req : '0;
        if (pick_any) begin
          a_lat_d = a_in[pick_idx];
          b_lat_d = b_in[pick_idx];
          gnt_d   = pick_oh;
          win_d   = pick_idx;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          res_d   = xu_z;
          mis_d   = (xu_z != (a_lat_q ^ b_lat_q));
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        gnt_d   = '0;
        ptr_d   = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      req_q   <= '0;
      cnt_q   <= '0;
      a_lat_q <= '0;
      b_lat_q <= '0;
      res_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      a_lat_q <= a_lat_d;
      b_lat_q <= b_lat_d;
      res_q   <= res_d;
      mis_q   <= mis_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = (state_q == ST_DONE) ? gnt_q : '0;
  assign busy     = (state_q != ST_IDLE);
  assign result   = res_q;
  assign mismatch = mis_q;
  assign xu_a     = a_lat_q;
  assign xu_b     = b_lat_q;
endmodule

// File: tb/tb_xor_unit_scheduler.sv
module tb_xor_unit_scheduler;
  localparam int N = 4;
  localparam int W = 4;
  localparam int S = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req;
  logic [N-1:0][W-1:0] a_in, b_in;
  logic [N-1:0]        gnt, done;
  logic [W-1:0]        result, xu_a, xu_b, xu_z;
  logic                mismatch, busy;
  logic                fault;

  int tests = 0;
  int fails = 0;
  int mptr  = 0;

  always #5 clk = ~clk;

  // Shared gate unit with propagation delay; fault swaps every XOR for an AND.
  assign #2 xu_z = fault ? (xu_a & xu_b) : (xu_a ^ xu_b);

  xor_unit_scheduler #(.N_REQ(N), .W(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .result(result), .mismatch(mismatch),
    .xu_a(xu_a), .xu_b(xu_b), .xu_z(xu_z), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first requester at or after p, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (p + i) % N;
      if (((r >> j) & 4'b1) != 4'b0) return j;
    end
    return -1;
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < 60);
    chk("done_seen", 32'(done != '0), 32'd1);
  endtask

  task automatic rand_operands();
    for (int i = 0; i < N; i++) begin
      a_in[i] = W'($urandom);
      b_in[i] = W'($urandom);
    end
  endtask

  // One isolated operation from a quiet IDLE; req dropped after done.
  task automatic do_op(input logic [N-1:0] r, input logic [W-1:0] aw,
                       input logic [W-1:0] bw, input logic flt, input string tag);
    int w, n;
    logic [W-1:0] ez;
    @(negedge clk);
    rand_operands();
    w = pick(r, mptr);
    a_in[w] = aw;
    b_in[w] = bw;
    fault = flt;
    req = r;
    ez = flt ? (aw & bw) : (aw ^ bw);
    wait_done(n);
    chk({tag, "_lat"},  32'(n), 32'(S + 2));
    chk({tag, "_done"}, 32'(done), 32'(1 << w));
    chk({tag, "_gnt"},  32'(gnt), 32'(1 << w));
    chk({tag, "_res"},  32'(result), 32'(ez));
    chk({tag, "_mis"},  32'(mismatch), 32'(ez != (aw ^ bw)));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    req = '0;
    mptr = (w + 1) % N;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_gnt0"},  32'(gnt), 32'd0);
    chk({tag, "_res_hold"}, 32'(result), 32'(ez));
  endtask

  // Requests held continuously for cnt operations.
  task automatic run_held(input logic [N-1:0] r, input int cnt, input string tag);
    int w, n;
    @(negedge clk);
    rand_operands();
    fault = 1'b0;
    req = r;
    for (int k = 0; k < cnt; k++) begin
      wait_done(n);
      w = pick(r, mptr);
      chk({tag, "_done"}, 32'(done), 32'(1 << w));
      chk({tag, "_res"},  32'(result), 32'(a_in[w] ^ b_in[w]));
      chk({tag, "_gap"},  32'(n), (k == 0) ? 32'(S + 2) : 32'(S + 3));
      mptr = (w + 1) % N;
    end
    req = '0;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req = '0; a_in = '0; b_in = '0; fault = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_mis", 32'(mismatch), 32'd0);
    chk("rst_xua", 32'(xu_a), 32'd0);
    chk("rst_xub", 32'(xu_b), 32'd0);
    rst_n = 1'b1;

    do_op(4'b0001, 4'hA, 4'h6, 1'b0, "single");
    chk("single_c", 32'(result), 32'hC);
    do_op(4'b1000, 4'hF, 4'h0, 1'b1, "fault");
    chk("fault_flag", 32'(mismatch), 32'd1);

    run_held(4'b1111, 5, "fair");
    do_op(4'b0100, W'($urandom), W'($urandom), 1'b0, "pre_wrap");
    run_held(4'b0101, 2, "wrap");

    // Operand change during SETTLE must not reach the unit.
    @(negedge clk);
    fault = 1'b0;
    a_in[1] = 4'h3;
    b_in[1] = 4'h1;
    req = 4'b0010;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 20);
    chk("chg_gnt", 32'(gnt), 32'(1 << pick(4'b0010, mptr)));
    chk("chg_xua0", 32'(xu_a), 32'h3);
    a_in[1] = 4'hF;
    req = '0;
    @(negedge clk);
    chk("chg_xua1", 32'(xu_a), 32'h3);
    chk("chg_busy", 32'(busy), 32'd1);
    wait_done(n);
    chk("chg_res", 32'(result), 32'h2);
    chk("chg_mis", 32'(mismatch), 32'd0);
    mptr = 2;
    @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      logic [N-1:0] r;
      r = N'($urandom_range(1, 15));
      do_op(r, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "rand");
    end
    fault = 1'b0;

    // Reset in the middle of SETTLE aborts the operation.
    @(negedge clk);
    rand_operands();
    req = 4'b0110;
    n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < 20);
    chk("mid_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_gnt", 32'(gnt), 32'd0);
    chk("mid_busy0", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_xua", 32'(xu_a), 32'd0);
    chk("mid_res", 32'(result), 32'd0);
    req = '0;
    mptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'b1010, 4'h5, 4'h9, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/xor_unit_scheduler.md
Name: xor_unit_scheduler

Overview:
- Round-robin scheduler that shares one combinational, delay-annotated XOR gate unit between N_REQ requesters.
- Latches the granted requester's operands and drives them onto the shared unit.
- Waits a programmed number of settle cycles for the gate delays to resolve, then captures the unit output.
- Returns the result to the requester and checks it against an internally computed XOR, flagging any mismatch.
- Sits between the testbench or system requesters and the gate-level XOR datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 4, operand width in bits; the shared unit is W instances of the 1-bit XOR gate.
- SETTLE_CYCLES, 2, clock cycles allowed for the gate path to settle (1..15).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester request level.
- a_in  input  N_REQ*W  operand A; slice i belongs to requester i.
- b_in  input  N_REQ*W  operand B; slice i belongs to requester i.
- gnt  output  N_REQ  one-hot grant; high from latch through the DONE cycle.
- done  output  N_REQ  one-hot, one-cycle completion pulse.
- result  output  W  captured unit output; valid while done is high, held afterwards.
- mismatch  output  1  high with done when the captured value differs from a_lat^b_lat; held afterwards.
- xu_a  output  W  operand A driven to the shared XOR unit.
- xu_b  output  W  operand B driven to the shared XOR unit.
- xu_z  input  W  output of the shared XOR unit.
- busy  output  1  high in SETTLE and DONE.

Behaviour:
- Clock and reset:
  - Single clock clk; rst_n is asynchronous and active-low. Both are fixed.
  - On reset, all outputs go to 0, the state goes to IDLE, the round-robin pointer goes to 0, and the settle counter and operand latches go to 0.
  - Reset asserted mid-operation aborts the operation. No done pulse is issued for the aborted request.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - If any req bit is high, the winner is the first set bit searching from ptr upward with wrap-around.
  - At the next edge, latch a_in and b_in for the winner into a_lat and b_lat.
  - At the same edge, set gnt one-hot, load cnt = SETTLE_CYCLES-1, and go to SETTLE.
  - xu_a and xu_b are driven from a_lat and b_lat and are stable for the whole operation.
- SETTLE:
  - Decrement cnt each cycle. The state lasts exactly SETTLE_CYCLES cycles.
  - When cnt==0, at the next edge capture result <= xu_z and mismatch <= (xu_z != a_lat^b_lat), then go to DONE.
- DONE:
  - Lasts exactly one cycle. done[winner] is high and gnt is held.
  - At the next edge: gnt <= 0, ptr <= winner+1 mod N_REQ, go to IDLE.
- Latency: with req sampled high at edge k, done is high in the cycle following edge k+1+SETTLE_CYCLES.
- Throughput: one operation per SETTLE_CYCLES+3 cycles, because IDLE always lasts at least one cycle.
- Request rules:
  - Operands are sampled once, at grant. Changes to a_in or b_in afterwards are ignored.
  - req dropping mid-operation does not abort; the operation completes and done still pulses.
  - A requester holding req through done is re-eligible, but only after the others under round-robin order.
  - Simultaneous requests are resolved by ptr only; there is no fixed priority.
  - With a single requester continuously requesting, it is granted every operation.
- Pointer wrap: ptr = N_REQ-1 advances to 0.
- result and mismatch hold their last values until the next DONE. Each is overwritten every operation, so mismatch is not sticky.

Decomposition:
- Shared package xor_sched_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_DONE=2'd2;
  - the counter width constant CNT_W=4.
- One sub-module, rr_pick: combinational round-robin winner select.
  - Inputs: req and ptr.
  - Outputs: a one-hot grant vector and the binary winner index.
- The XOR unit itself is instantiated by the testbench or system, not inside this block.

Test Plan:
- Single request, correct XOR model: req=4'b0001, a=4'hA, b=4'h6, SETTLE_CYCLES=2.
  - Required: done[0] high 4 cycles after the req sampling edge, result=4'hC, mismatch=0.
- Faulty AND-of-ANDs model on xu_z, a=4'hF, b=4'h0.
  - Required: result=4'h0, mismatch=1.
- Round-robin fairness: req=4'b1111 held continuously.
  - Required: grants in order 0,1,2,3,0. Each done pulse is one cycle. Consecutive done pulses are 5 cycles apart.
- Wrap and skip: ptr=3 after serving requester 2, req=4'b0101.
  - Required: next grant goes to 0, then to 2.
- Operand change mid-op: a_in slice changes from 4'h3 to 4'hF during SETTLE, with b=4'h1.
  - Required: xu_a stays 4'h3 and result=4'h2.
- Reset mid-SETTLE: rst_n pulled low.
  - Required: gnt, busy, done, xu_a and result are 0 immediately. After release, the first grant goes to the lowest set req bit.
